trig_burst_gen: RTL and testbench

TRIG_BURST_GEN -- requirements
Module: trig_burst_gen

---
 rtl/trig_burst_gen_pkg.sv | 20 ++
 rtl/tbg_trig_detect.sv | 106 ++++++++++
 rtl/trig_burst_gen.sv | 209 ++++++++++++++++++++
 tb/tb_trig_burst_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_burst_gen_pkg.sv
// Shared constants for the triggered burst generator: FSM state codes,
// trigger-source select value and default parameter values.
package trig_burst_gen_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 32;

    // Value of the TrigSrc MSB that selects the external trigger edge
    localparam logic TRIG_SEL_EXT = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARMED = 3'd1;
    localparam state_t ST_DELAY = 3'd2;
    localparam state_t ST_HIGH  = 3'd3;
    localparam state_t ST_LOW   = 3'd4;

endpackage

// File: rtl/tbg_trig_detect.sv
// Trigger detector: registers samples/ExtTrig, finds a threshold crossing on the
// selected channel or an ExtTrig rising edge; optional hysteresis (TRIG_BURST_GEN_HYST_EN).
module tbg_trig_detect
    import trig_burst_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int TS_W   = $clog2(DEF_NUM_CH) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic                     i_ext_trig,
    input  logic [TS_W-1:0]          i_trig_src,
    input  logic [DATA_W-1:0]        i_trig_level,
`ifdef TRIG_BURST_GEN_HYST_EN
    input  logic [DATA_W-1:0]        i_hyst_level,
    input  logic                     i_arm_rise,
`endif
    output logic [NUM_CH*DATA_W-1:0] o_samples,
    output logic                     o_hit
);

    logic [NUM_CH*DATA_W-1:0] r_in;
    logic [NUM_CH*DATA_W-1:0] r_prev;
    logic                     r_ext;
    logic                     r_ext_d;
    logic                     r_hit;

    logic signed [DATA_W-1:0] w_cur;
    logic signed [DATA_W-1:0] w_prev;
    logic signed [DATA_W-1:0] w_lvl;
    logic                     w_ch_ok;
    logic                     w_sel_ext;
    logic                     w_cross;
    logic                     w_ch_hit;
    int                       w_idx;

    assign w_sel_ext = (i_trig_src[TS_W-1] == TRIG_SEL_EXT);
    assign w_lvl     = i_trig_level;

    // Index from the low TrigSrc bits; an index past the last channel never hits
    always_comb begin
        w_idx   = int'(i_trig_src) % (1 << (TS_W - 1));
        w_cur   = '0;
        w_prev  = '0;
        w_ch_ok = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == w_idx) begin
                w_cur   = r_in[c*DATA_W +: DATA_W];
                w_prev  = r_prev[c*DATA_W +: DATA_W];
                w_ch_ok = 1'b1;
            end
        end
    end

    assign w_cross = w_ch_ok && (w_prev < w_lvl) && (w_cur >= w_lvl);

`ifdef TRIG_BURST_GEN_HYST_EN
    logic                     r_qual;
    logic signed [DATA_W+1:0] w_diff;
    logic signed [DATA_W+1:0] w_min;
    logic signed [DATA_W-1:0] w_thr;

    assign w_min  = {3'b111, {(DATA_W-1){1'b0}}};
    assign w_diff = {{2{i_trig_level[DATA_W-1]}}, i_trig_level} - {2'b00, i_hyst_level};
    assign w_thr  = (w_diff < w_min) ? {1'b1, {(DATA_W-1){1'b0}}} : w_diff[DATA_W-1:0];

    assign w_ch_hit = w_cross && r_qual;

    // A hit disqualifies the channel until it drops below TrigLevel-HystLevel
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_qual <= 1'b1;
        end else if (i_arm_rise) begin
            r_qual <= 1'b1;
        end else if (!w_sel_ext && w_ch_hit) begin
            r_qual <= 1'b0;
        end else if (w_ch_ok && (w_cur < w_thr)) begin
            r_qual <= 1'b1;
        end
    end
`else
    assign w_ch_hit = w_cross;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_in    <= '0;
            r_prev  <= '0;
            r_ext   <= 1'b0;
            r_ext_d <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_in    <= i_data;
            r_prev  <= r_in;
            r_ext   <= i_ext_trig;
            r_ext_d <= r_ext;
            r_hit   <= w_sel_ext ? (r_ext & ~r_ext_d) : w_ch_hit;
        end
    end

    assign o_samples = r_in;
    assign o_hit     = r_hit;

endmodule

// File: rtl/trig_burst_gen.sv
// Triggered pulse-burst generator driving masked channels between two levels.
// Optional TRIG_BURST_GEN_HYST_EN adds HystLevel for threshold-trigger hysteresis.
//
// state    | meaning
// IDLE     | disarmed, waiting for an Arm rising edge
// ARMED    | waiting for a trigger hit
// DELAY    | counting Delay cycles before the first pulse
// HIGH     | masked channels at HighLevel for Width cycles
// LOW      | remainder of Period at LowLevel; then next pulse or finish
module trig_burst_gen
    import trig_burst_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_CH*DATA_W-1:0]   InData,
    input  logic                       ExtTrig,
    input  logic                       Arm,
    input  logic                       Rearm,
    input  logic [$clog2(NUM_CH):0]    TrigSrc,
    input  logic [DATA_W-1:0]          TrigLevel,
`ifdef TRIG_BURST_GEN_HYST_EN
    input  logic [DATA_W-1:0]          HystLevel,
`endif
    input  logic [CNT_W-1:0]           Delay,
    input  logic [CNT_W-1:0]           Width,
    input  logic [CNT_W-1:0]           Period,
    input  logic [15:0]                Count,
    input  logic [DATA_W-1:0]          HighLevel,
    input  logic [DATA_W-1:0]          LowLevel,
    input  logic [NUM_CH-1:0]          ChMask,
    output logic [NUM_CH*DATA_W-1:0]   OutData,
    output logic                       Busy,
    output logic                       Done,
    output logic [15:0]                PulseCnt
);

    localparam int TS_W = $clog2(NUM_CH) + 1;

    state_t                   r_state;
    logic                     r_arm_d;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_wid_m1;
    logic [CNT_W-1:0]         r_low_m1;
    logic [15:0]              r_burst;
    logic [15:0]              r_count;
    logic [DATA_W-1:0]        r_high;
    logic [DATA_W-1:0]        r_low;
    logic [NUM_CH-1:0]        r_mask;
    logic                     r_done;
    logic [15:0]              r_pulse_cnt;
    logic [NUM_CH*DATA_W-1:0] r_out;

    logic [NUM_CH*DATA_W-1:0] w_samples;
    logic                     w_hit;
    logic                     w_arm_rise;
    logic [CNT_W-1:0]         w_wid_eff;
    logic [CNT_W-1:0]         w_low_len;
    logic [15:0]              w_pulse_inc;
    logic                     w_busy;
    logic                     w_drive_high;
    logic [NUM_CH-1:0]        w_mask;
    logic [DATA_W-1:0]        w_hi;
    logic [DATA_W-1:0]        w_lo;
    logic [NUM_CH*DATA_W-1:0] w_out_nxt;

    tbg_trig_detect #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .TS_W   (TS_W)
    ) u_trig_detect (
        .i_clk        (Clk),
        .i_reset      (Reset),
        .i_data       (InData),
        .i_ext_trig   (ExtTrig),
        .i_trig_src   (TrigSrc),
        .i_trig_level (TrigLevel),
`ifdef TRIG_BURST_GEN_HYST_EN
        .i_hyst_level (HystLevel),
        .i_arm_rise   (w_arm_rise),
`endif
        .o_samples    (w_samples),
        .o_hit        (w_hit)
    );

    assign w_arm_rise  = Arm & ~r_arm_d;
    assign w_wid_eff   = (Width == '0) ? CNT_W'(1) : Width;
    assign w_low_len   = (Period > w_wid_eff) ? (Period - w_wid_eff) : CNT_W'(1);
    assign w_pulse_inc = (r_pulse_cnt == 16'hFFFF) ? r_pulse_cnt : r_pulse_cnt + 16'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_arm_d     <= 1'b1;   // a level already high at release is not an edge
            r_cnt       <= '0;
            r_wid_m1    <= '0;
            r_low_m1    <= '0;
            r_burst     <= '0;
            r_count     <= '0;
            r_high      <= '0;
            r_low       <= '0;
            r_mask      <= '0;
            r_done      <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_arm_d <= Arm;
            if (w_arm_rise) begin
                r_done      <= 1'b0;
                r_pulse_cnt <= '0;
            end
            if (!Arm) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_arm_rise) r_state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (w_hit) begin
                            r_count  <= Count;
                            r_wid_m1 <= w_wid_eff - CNT_W'(1);
                            r_low_m1 <= w_low_len - CNT_W'(1);
                            r_high   <= HighLevel;
                            r_low    <= LowLevel;
                            r_mask   <= ChMask;
                            if (Delay == '0) begin
                                r_state     <= ST_HIGH;
                                r_cnt       <= w_wid_eff - CNT_W'(1);
                                r_burst     <= 16'd1;
                                r_pulse_cnt <= w_pulse_inc;
                            end else begin
                                r_state <= ST_DELAY;
                                r_cnt   <= Delay - CNT_W'(1);
                                r_burst <= '0;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (r_cnt == '0) begin
                            r_state     <= ST_HIGH;
                            r_cnt       <= r_wid_m1;
                            r_burst     <= r_burst + 16'd1;
                            r_pulse_cnt <= w_pulse_inc;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_LOW;
                            r_cnt   <= r_low_m1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_LOW: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else if ((r_count != 16'd0) && (r_burst == r_count)) begin
                            r_done  <= 1'b1;
                            r_state <= Rearm ? ST_ARMED : ST_IDLE;
                        end else begin
                            r_state     <= ST_HIGH;
                            r_cnt       <= r_wid_m1;
                            r_burst     <= r_burst + 16'd1;
                            r_pulse_cnt <= w_pulse_inc;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_busy = (r_state == ST_DELAY) || (r_state == ST_HIGH) || (r_state == ST_LOW);

    // Burst-time settings are the ones captured at the hit; live ones apply otherwise
    always_comb begin
        w_drive_high = Arm && (r_state == ST_HIGH);
        w_mask       = w_busy ? r_mask : ChMask;
        w_hi         = w_busy ? r_high : HighLevel;
        w_lo         = w_busy ? r_low  : LowLevel;
        w_out_nxt    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_mask[c]) begin
                w_out_nxt[c*DATA_W +: DATA_W] = w_drive_high ? w_hi : w_lo;
            end else begin
                w_out_nxt[c*DATA_W +: DATA_W] = w_samples[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_out <= '0;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    assign OutData  = r_out;
    assign Busy     = w_busy;
    assign Done     = r_done;
    assign PulseCnt = r_pulse_cnt;

endmodule

// File: tb/tb_trig_burst_gen.sv
// Directed self-checking bench for trig_burst_gen with hand-computed cycle timing.
module tb_trig_burst_gen;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    localparam logic [15:0] HI  = 16'd500;
    localparam logic [15:0] LO  = 16'hFE0C;   // -500
    localparam logic [15:0] M10 = 16'hFFF6;   // -10
    localparam logic [15:0] M200 = 16'hFF38;  // -200

    logic                     Clk = 1'b0;
    logic                     Reset;
    logic [NUM_CH*DATA_W-1:0] InData;
    logic                     ExtTrig, Arm, Rearm;
    logic [2:0]               TrigSrc;
    logic [DATA_W-1:0]        TrigLevel;
`ifdef TRIG_BURST_GEN_HYST_EN
    logic [DATA_W-1:0]        HystLevel;
`endif
    logic [CNT_W-1:0]         Delay, Width, Period;
    logic [15:0]              Count;
    logic [DATA_W-1:0]        HighLevel, LowLevel;
    logic [NUM_CH-1:0]        ChMask;
    logic [NUM_CH*DATA_W-1:0] OutData;
    logic                     Busy, Done;
    logic [15:0]              PulseCnt;

    int n_checks = 0;
    int n_errors = 0;

    trig_burst_gen #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .InData    (InData),
        .ExtTrig   (ExtTrig),
        .Arm       (Arm),
        .Rearm     (Rearm),
        .TrigSrc   (TrigSrc),
        .TrigLevel (TrigLevel),
`ifdef TRIG_BURST_GEN_HYST_EN
        .HystLevel (HystLevel),
`endif
        .Delay     (Delay),
        .Width     (Width),
        .Period    (Period),
        .Count     (Count),
        .HighLevel (HighLevel),
        .LowLevel  (LowLevel),
        .ChMask    (ChMask),
        .OutData   (OutData),
        .Busy      (Busy),
        .Done      (Done),
        .PulseCnt  (PulseCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_ch(input int c, input logic [15:0] v);
        InData[c*16 +: 16] = v;
    endtask

    function automatic logic [15:0] out_ch(input int c);
        return OutData[c*16 +: 16];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [40:0] obs_b, exp_b;
        logic        any_busy;

        Reset = 1'b1; Arm = 1'b0; Rearm = 1'b0; ExtTrig = 1'b0;
        TrigSrc = 3'b100; TrigLevel = '0;
`ifdef TRIG_BURST_GEN_HYST_EN
        HystLevel = '0;
`endif
        Delay = '0; Width = '0; Period = '0; Count = 16'd1;
        HighLevel = HI; LowLevel = LO; ChMask = 4'b0001;
        InData = '0;
        set_ch(0, 16'd11); set_ch(1, 16'd900); set_ch(2, 16'd33); set_ch(3, 16'd44);

        // Reset state
        tick(3);
        chk("rst_out", OutData, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_pcnt", PulseCnt, 0);
        Reset = 1'b0;
        tick(3);
        chk("idle_mask_lo", out_ch(0), LO);
        chk("idle_pass_ch3", out_ch(3), 16'd44);

        // Single 1-cycle pulse from ExtTrig, Delay=0 Width=0
        Arm = 1'b1;
        tick(3);
        ExtTrig = 1'b1; tick(1);
        ExtTrig = 1'b0; tick(1);
        chk("a_busy_e1", Busy, 0);
        tick(1);
        chk("a_busy_e2", Busy, 1);
        chk("a_lo_e2", out_ch(0), LO);
        tick(1);
        chk("a_hi_e3", out_ch(0), HI);
        chk("a_busy_e3", Busy, 1);
        chk("a_pcnt", PulseCnt, 1);
        chk("a_pass_ch1", out_ch(1), 16'd900);
        tick(1);
        chk("a_busy_e4", Busy, 0);
        chk("a_done", Done, 1);
        chk("a_lo_e4", out_ch(0), LO);

        // Threshold crossing on ch1, Delay=5 Width=3 Period=10 Count=3
        Arm = 1'b0; tick(1);
        Arm = 1'b1; tick(1);
        chk("b_done_clr", Done, 0);
        chk("b_pcnt_clr", PulseCnt, 0);
        TrigSrc = 3'b001; TrigLevel = 16'd1000;
        Delay = 5; Width = 3; Period = 10; Count = 3; ChMask = 4'b0101;
        set_ch(1, 16'd950);
        tick(2);
        set_ch(1, 16'd1100);
        obs_b = '0; exp_b = '0;
        for (int e = 0; e <= 40; e++) begin
            tick(1);
            obs_b[e] = (out_ch(0) == HI) && (out_ch(2) == HI);
            exp_b[e] = (e >= 8) && (e <= 30) && (((e - 8) % 10) < 3);
            if (e == 3) begin
                HighLevel = 16'd7; Width = 1; Period = 2; Count = 1; ChMask = 4'b1111; Delay = 0;
            end
            if (e == 2)  chk("b_busy_e2", Busy, 1);
            if (e == 9)  chk("b_held_mask", out_ch(3), 16'd44);
            if (e == 36) chk("b_done_e36", Done, 0);
            if (e == 37) begin
                chk("b_done_e37", Done, 1);
                chk("b_busy_e37", Busy, 0);
                chk("b_pcnt", PulseCnt, 3);
            end
        end
        chk("b_pulses", obs_b, exp_b);

        // Continuous pulses, Arm dropped mid-burst
        Arm = 1'b0; tick(1);
        HighLevel = HI; LowLevel = LO; ChMask = 4'b0001; TrigSrc = 3'b100;
        Delay = 0; Width = 1; Period = 4; Count = 0; Rearm = 1'b0;
        Arm = 1'b1; tick(2);
        ExtTrig = 1'b1; tick(1);
        ExtTrig = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            if (e == 3)  chk("c_hi_e3", out_ch(0), HI);
            if (e == 5)  chk("c_lo_e5", out_ch(0), LO);
            if (e == 7)  chk("c_hi_e7", out_ch(0), HI);
            if (e == 10) chk("c_pcnt", PulseCnt, 3);
        end
        Arm = 1'b0; tick(1);
        chk("c_disarm_busy", Busy, 0);
        chk("c_disarm_lo", out_ch(0), LO);
        tick(2);
        chk("c_done", Done, 0);

        // Rearm with one ignored mid-burst edge and a later second burst
        Rearm = 1'b1; Delay = 2; Width = 2; Period = 4; Count = 2;
        Arm = 1'b1; tick(1);
        tick(1);
        ExtTrig = 1'b1; tick(1);
        ExtTrig = 1'b0;
        any_busy = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            if (e == 6) ExtTrig = 1'b1;
            if (e == 7) ExtTrig = 1'b0;
            tick(1);
            if (e == 5) chk("d_hi_e5", out_ch(0), HI);
            if (e == 11) begin
                chk("d_busy_e11", Busy, 1);
                chk("d_done_e11", Done, 0);
            end
            if (e == 12) begin
                chk("d_busy_e12", Busy, 0);
                chk("d_done_e12", Done, 1);
                chk("d_pcnt", PulseCnt, 2);
            end
            if (e >= 13) any_busy = any_busy | Busy;
        end
        chk("d_ignored", any_busy, 0);
        ExtTrig = 1'b1; tick(1);
        ExtTrig = 1'b0; tick(2);
        chk("d2_busy", Busy, 1);
        tick(3);
        chk("d2_hi", out_ch(0), HI);
        chk("d2_pcnt", PulseCnt, 3);
        chk("d2_done_held", Done, 1);

        // Reset while HIGH
        Reset = 1'b1; tick(1);
        chk("e_rst_out", OutData, 0);
        chk("e_rst_busy", Busy, 0);
        chk("e_rst_done", Done, 0);
        chk("e_rst_pcnt", PulseCnt, 0);

        // Arm held high through reset release must not arm
        Reset = 1'b0; tick(3);
        ExtTrig = 1'b1; tick(1);
        ExtTrig = 1'b0; tick(4);
        chk("f_no_arm_busy", Busy, 0);
        chk("f_no_arm_pcnt", PulseCnt, 0);

        // Channel crossing around zero; hysteresis build needs a drop below -100
        Arm = 1'b0; tick(1);
        TrigSrc = 3'b010; TrigLevel = 16'd0;
`ifdef TRIG_BURST_GEN_HYST_EN
        HystLevel = 16'd100;
`endif
        Delay = 0; Width = 0; Period = 0; Count = 1; Rearm = 1'b1;
        set_ch(2, M10);
        Arm = 1'b1; tick(8);
        chk("g_pcnt0", PulseCnt, 0);
        set_ch(2, 16'd10); tick(8);
        chk("g_pcnt1", PulseCnt, 1);
        set_ch(2, M10); tick(8);
        set_ch(2, 16'd10); tick(8);
`ifdef TRIG_BURST_GEN_HYST_EN
        chk("g_pcnt2", PulseCnt, 1);
`else
        chk("g_pcnt2", PulseCnt, 2);
`endif
        set_ch(2, M200); tick(8);
        set_ch(2, 16'd10); tick(8);
`ifdef TRIG_BURST_GEN_HYST_EN
        chk("g_pcnt3", PulseCnt, 2);
`else
        chk("g_pcnt3", PulseCnt, 3);
`endif
        chk("g_done", Done, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
